// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and defaults for the instruction-fetch front end
package ifetch_pkg;

    localparam int AW_DEF    = 8;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // Prefetch FIFO entry: fetch address in the upper bits, fetched byte below.
    typedef struct packed {
        logic [AW_DEF-1:0] pc;
        logic [DW_DEF-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/ifetch_prefetch_if.sv
// rtl/ifetch_prefetch_if.sv - one MemController requester port
interface ifetch_prefetch_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          rden;
    logic          wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          acq;
    logic [DW-1:0] q;

    modport master (output rden, wren, addr, din, input acq, q);
    modport slave  (input rden, wren, addr, din, output acq, q);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push/pop/clear, occupancy count and head read
module sync_fifo #(
    parameter  int W     = 16,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !clear) mem[wr_ptr] <= push_data;
    end

    // Empty FIFO reads as zero so the head outputs are defined out of reset.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifetch_prefetch.sv
// rtl/ifetch_prefetch.sv - fetch PC walker, MemController requester and prefetch buffer
module ifetch_prefetch
    import ifetch_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter int            DW       = DW_DEF,
    parameter int            DEPTH    = DEPTH_DEF,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pc_load,
    input  logic [AW-1:0]          pc_target,
    input  logic                   instr_ready,
    output logic                   instr_valid,
    output logic [DW-1:0]          instr_data,
    output logic [AW-1:0]          instr_pc,
    ifetch_prefetch_if.master      mem,
    output logic [AW-1:0]          fetch_pc,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t     state, state_n;
    logic             rden_q, rden_n;
    logic [AW-1:0]    addr_q, addr_n;
    logic [AW-1:0]    pc_q, pc_n;
    logic             fifo_push, fifo_pop, fifo_clear;
    logic [AW+DW-1:0] head;
    logic [CW:0]      post_count;

    assign instr_valid = (fifo_count != '0);
    assign fifo_pop    = instr_valid && instr_ready && !pc_load;
    assign post_count  = {1'b0, fifo_count} + (CW+1)'(1) - (CW+1)'(fifo_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rden_q <= 1'b0;
            addr_q <= '0;
            pc_q   <= RESET_PC;
        end else begin
            state  <= state_n;
            rden_q <= rden_n;
            addr_q <= addr_n;
            pc_q   <= pc_n;
        end
    end

    always_comb begin
        state_n    = state;
        rden_n     = rden_q;
        addr_n     = addr_q;
        pc_n       = pc_q;
        fifo_push  = 1'b0;
        fifo_clear = 1'b0;
        case (state)
            IDLE: begin
                if (pc_load) begin
                    pc_n       = pc_target;
                    fifo_clear = 1'b1;
                end else if (fifo_count < CW'(DEPTH)) begin
                    state_n = REQ;
                    rden_n  = 1'b1;
                    addr_n  = pc_q;
                end
            end
            REQ: begin
                if (pc_load) begin
                    // A read still outstanding must be retired before a new address is issued.
                    pc_n       = pc_target;
                    fifo_clear = 1'b1;
                    if (mem.acq) begin
                        state_n = IDLE;
                        rden_n  = 1'b0;
                    end else begin
                        state_n = DISCARD;
                    end
                end else if (mem.acq) begin
                    fifo_push = 1'b1;
                    pc_n      = addr_q + 1'b1;
                    if (post_count < (CW+1)'(DEPTH)) begin
                        addr_n = addr_q + 1'b1;
                    end else begin
                        state_n = IDLE;
                        rden_n  = 1'b0;
                    end
                end
            end
            DISCARD: begin
                if (pc_load) begin
                    pc_n       = pc_target;
                    fifo_clear = 1'b1;
                end
                if (mem.acq) begin
                    state_n = IDLE;
                    rden_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                rden_n  = 1'b0;
            end
        endcase
    end

    sync_fifo #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_data ({addr_q, mem.q}),
        .pop       (fifo_pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign instr_pc   = head[AW+DW-1:DW];
    assign instr_data = head[DW-1:0];
    assign fetch_pc   = pc_q;
    assign mem.rden   = rden_q;
    assign mem.addr   = addr_q;
    assign mem.wren   = 1'b0;
    assign mem.din    = '0;

endmodule
